req_responder: RTL and testbench

REQ_RESPONDER -- requirements
Module: req_responder

---
 rtl/req_responder.sv | 100 ++++++++++
 tb/tb_req_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/req_responder.sv
// Per-address version counters with an in-order read-response FIFO.
// Writes bump a version; reads queue {addr, version} for the consumer.
module req_responder #(
  parameter int WIDTH     = 2,
  parameter int LENGTH    = 4,
  parameter int LOGLENGTH = 2,
  parameter int VWIDTH    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              validin,
  input  logic [WIDTH-1:0]  addrin,
  input  logic              isread,
  output logic              busy,
  output logic              rspvalid,
  output logic [WIDTH-1:0]  rspaddr,
  output logic [VWIDTH-1:0] rspdata,
  input  logic              rspack,
  output logic              overflow
);

  localparam int                   DEPTH = 2**WIDTH;
  localparam logic [LOGLENGTH:0]   FULL  = (LOGLENGTH+1)'(LENGTH);

  logic [VWIDTH-1:0]    ver_q       [DEPTH];
  logic [VWIDTH-1:0]    ver_d       [DEPTH];
  logic [WIDTH-1:0]     fifo_addr_q [LENGTH];
  logic [WIDTH-1:0]     fifo_addr_d [LENGTH];
  logic [VWIDTH-1:0]    fifo_data_q [LENGTH];
  logic [VWIDTH-1:0]    fifo_data_d [LENGTH];
  logic [LOGLENGTH-1:0] readhead_q, readhead_d;
  logic [LOGLENGTH-1:0] readtail_q, readtail_d;
  logic [LOGLENGTH:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 pop, push, is_rd;

  assign busy     = (count_q == FULL);
  assign rspvalid = (count_q != '0);
  assign rspaddr  = fifo_addr_q[readhead_q];
  assign rspdata  = fifo_data_q[readhead_q];
  assign overflow = overflow_q;

  always_comb begin
    ver_d       = ver_q;
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    readhead_d  = readhead_q;
    readtail_d  = readtail_q;
    count_d     = count_q;
    overflow_d  = overflow_q;

    pop   = rspvalid && rspack;
    is_rd = validin && isread;
    // A pop frees the head slot this edge, so a full FIFO can still take a read.
    push  = is_rd && (!busy || pop);

    if (validin && !isread)
      ver_d[addrin] = ver_q[addrin] + VWIDTH'(1);

    if (push) begin
      fifo_addr_d[readtail_q] = addrin;
      fifo_data_d[readtail_q] = ver_q[addrin];
      readtail_d              = readtail_q + LOGLENGTH'(1);
    end
    if (pop)
      readhead_d = readhead_q + LOGLENGTH'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (LOGLENGTH+1)'(1);
      2'b01:   count_d = count_q - (LOGLENGTH+1)'(1);
      default: count_d = count_q;
    endcase

    if (is_rd && !push)
      overflow_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)  ver_q[i] <= '0;
      for (int i = 0; i < LENGTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      readhead_q <= '0;
      readtail_q <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      ver_q       <= ver_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
      readhead_q  <= readhead_d;
      readtail_q  <= readtail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_req_responder.sv
// Scoreboard bench for req_responder: expected responses are queued as reads
// are issued and compared against the head when the bench acknowledges.
module tb_req_responder;

  logic       clock, reset, validin, isread, rspack;
  logic [1:0] addrin;
  logic       busy, rspvalid, overflow;
  logic [1:0] rspaddr;
  logic [3:0] rspdata;

  int checks = 0;
  int errors = 0;

  logic [5:0] sb [$];
  logic [3:0] m_ver [4];

  req_responder #(.WIDTH(2), .LENGTH(4), .LOGLENGTH(2), .VWIDTH(4)) dut (
    .clock(clock), .reset(reset), .validin(validin), .addrin(addrin),
    .isread(isread), .busy(busy), .rspvalid(rspvalid), .rspaddr(rspaddr),
    .rspdata(rspdata), .rspack(rspack), .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of stimulus and advance the expected-response queue.
  task automatic step(input logic v, input logic [1:0] a, input logic r,
                      input logic k, input logic rst);
    logic pop, full;
    validin = v; addrin = a; isread = r; rspack = k; reset = rst;
    if (rst) begin
      sb.delete();
      for (int i = 0; i < 4; i++) m_ver[i] = 4'd0;
    end else begin
      pop  = k && (sb.size() != 0);
      full = (sb.size() == 4);
      if (pop) void'(sb.pop_front());
      if (v && r && (!full || pop)) sb.push_back({a, m_ver[a]});
      if (v && !r) m_ver[a] = m_ver[a] + 4'd1;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    checks++; if (rspvalid !== 1'b0) begin errors++; $display("FAIL reset_rspvalid got %b exp 0", rspvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_basic_read();
    validin = 1; isread = 1; addrin = 2'd1; rspack = 0;
    #1;
    checks++; if (rspvalid !== 1'b0) begin errors++; $display("FAIL no_bypass got %b exp 0", rspvalid); end
    step(1, 1, 1, 0, 0);
    checks++; if (rspvalid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", rspvalid); end
    checks++; if (rspaddr !== 2'd1 || rspdata !== 4'd0) begin errors++; $display("FAIL basic_head got %h/%h exp 1/0", rspaddr, rspdata); end
    step(0, 0, 0, 1, 0);
    checks++; if (rspvalid !== 1'b0) begin errors++; $display("FAIL basic_drained got %b exp 0", rspvalid); end
  endtask

  task automatic test_versions();
    repeat (3) step(1, 2, 0, 0, 0);
    step(1, 2, 1, 0, 0);
    checks++; if (rspvalid !== 1'b1 || rspdata !== 4'd3 || {rspaddr, rspdata} !== sb[0]) begin
      errors++; $display("FAIL ver_three got %b %h/%h exp 1 2/3", rspvalid, rspaddr, rspdata); end
    step(0, 0, 0, 1, 0);
    repeat (16) step(1, 3, 0, 0, 0);
    step(1, 3, 1, 0, 0);
    checks++; if (rspaddr !== 2'd3 || rspdata !== 4'd0) begin
      errors++; $display("FAIL ver_wrap got %h/%h exp 3/0", rspaddr, rspdata); end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_overflow();
    step(0, 0, 0, 1, 0);  // ack on empty must not disturb the count
    for (int i = 0; i < 4; i++) step(1, 2'(i), 1, 0, 0);
    checks++; if (busy !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL full_flags got busy=%b ovf=%b exp 1/0", busy, overflow); end
    step(1, 2, 1, 0, 0);
    checks++; if (busy !== 1'b1 || overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_set got busy=%b ovf=%b exp 1/1", busy, overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rspvalid !== 1'b1 || rspaddr !== 2'(i) || {rspaddr, rspdata} !== sb[0]) begin
        errors++; $display("FAIL ovf_order%0d got %b %h/%h exp 1 %0d/%h", i, rspvalid, rspaddr, rspdata, i, sb[0][3:0]); end
      step(0, 0, 0, 1, 0);
    end
    checks++; if (rspvalid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_after got v=%b b=%b o=%b exp 0/0/1", rspvalid, busy, overflow); end
  endtask

  task automatic test_full_push_pop();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 2, 1, 0, 0);
    step(1, 3, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    checks++; if (rspaddr !== 2'd1 || rspdata !== 4'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL fpp_head got %h/%h busy=%b exp 1/0 1", rspaddr, rspdata, busy); end
    step(1, 0, 1, 1, 0);
    checks++; if (busy !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL fpp_flags got busy=%b ovf=%b exp 1/0", busy, overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rspvalid !== 1'b1 || {rspaddr, rspdata} !== sb[0]) begin
        errors++; $display("FAIL fpp_order%0d got %b %h/%h exp 1 %h", i, rspvalid, rspaddr, rspdata, sb[0]); end
      if (i == 3) begin
        checks++; if (rspaddr !== 2'd0 || rspdata !== 4'd2) begin
          errors++; $display("FAIL fpp_last got %h/%h exp 0/2", rspaddr, rspdata); end
      end
      step(0, 0, 0, 1, 0);
    end
    checks++; if (rspvalid !== 1'b0) begin errors++; $display("FAIL fpp_drained got %b exp 0", rspvalid); end
  endtask

  task automatic test_rw_order();
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rspvalid !== 1'b1 || rspaddr !== 2'd1 || rspdata !== 4'(i + 1) || {rspaddr, rspdata} !== sb[0]) begin
        errors++; $display("FAIL rw_order%0d got %b %h/%h exp 1 1/%0d", i, rspvalid, rspaddr, rspdata, i + 1); end
      step(0, 0, 0, 1, 0);
    end
    checks++; if (rspvalid !== 1'b0) begin errors++; $display("FAIL rw_drained got %b exp 0", rspvalid); end
  endtask

  task automatic test_reset_mid();
    step(1, 3, 0, 0, 0);
    step(1, 3, 0, 0, 0);
    step(1, 3, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 2, 1, 0, 0);
    step(1, 3, 1, 0, 0);
    checks++; if (overflow !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_pre got ovf=%b busy=%b exp 1/1", overflow, busy); end
    step(1, 2, 1, 1, 1);
    checks++; if (rspvalid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL mid_reset got v=%b b=%b o=%b exp 0/0/0", rspvalid, busy, overflow); end
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 2'(i), 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rspvalid !== 1'b1 || rspaddr !== 2'(i) || rspdata !== 4'd0 || {rspaddr, rspdata} !== sb[0]) begin
        errors++; $display("FAIL mid_ver%0d got %b %h/%h exp 1 %0d/0", i, rspvalid, rspaddr, rspdata, i); end
      step(0, 0, 0, 1, 0);
    end
    checks++; if (rspvalid !== 1'b0) begin errors++; $display("FAIL mid_drained got %b exp 0", rspvalid); end
  endtask

  initial begin
    reset = 1; validin = 0; isread = 0; addrin = 0; rspack = 0;
    for (int i = 0; i < 4; i++) m_ver[i] = 4'd0;
    @(negedge clock);
    test_reset();
    test_basic_read();
    test_versions();
    test_overflow();
    test_full_push_pop();
    test_rw_order();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
